// File: rtl/cmd_arbiter.sv
// Two-requester command arbiter with a tag FIFO for routing read bursts.
// Round-robin grant into one output register; read beats go back to the issuer.
module cmd_arbiter #(
    parameter int TAG_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_valid,
    output logic         m0_ready,
    input  logic         m0_cmd_type,
    input  logic [26:0]  m0_addr,
    input  logic [5:0]   m0_burst_cnt,
    input  logic [127:0] m0_wt_data,
    input  logic [15:0]  m0_wt_mask,
    input  logic         m1_valid,
    output logic         m1_ready,
    input  logic         m1_cmd_type,
    input  logic [26:0]  m1_addr,
    input  logic [5:0]   m1_burst_cnt,
    input  logic [127:0] m1_wt_data,
    input  logic [15:0]  m1_wt_mask,
    output logic         push_valid,
    input  logic         push_ready,
    output logic         push_cmd_type,
    output logic [26:0]  push_addr,
    output logic [5:0]   push_burst_cnt,
    output logic [127:0] push_wt_data,
    output logic [15:0]  push_wt_mask,
    input  logic         rd_valid,
    input  logic [127:0] rd_data,
    output logic         m0_rd_valid,
    output logic [127:0] m0_rd_data,
    output logic         m0_rd_last,
    output logic         m1_rd_valid,
    output logic [127:0] m1_rd_data,
    output logic         m1_rd_last,
    output logic         rd_err
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] tag_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          tag_id [TAG_DEPTH];
    logic [5:0]    tag_bc [TAG_DEPTH];
    logic [5:0]    beat_cnt;
    logic          last_grant;

    logic load;
    logic tag_full;
    logic el0;
    logic el1;
    logic gnt0;
    logic gnt1;
    logic tag_push;
    logic tag_pop;
    logic tag_any;
    logic head_id;
    logic beat_last;

    // Full check uses the registered count, so a same-cycle pop frees nothing.
    always_comb begin
        load      = !push_valid || push_ready;
        tag_full  = tag_cnt == CW'(TAG_DEPTH);
        el0       = m0_valid && (m0_cmd_type || !tag_full);
        el1       = m1_valid && (m1_cmd_type || !tag_full);
        gnt0      = load && el0 && (!el1 || last_grant);
        gnt1      = load && el1 && (!el0 || !last_grant);
        tag_push  = (gnt0 && !m0_cmd_type) || (gnt1 && !m1_cmd_type);
        tag_any   = tag_cnt != '0;
        head_id   = tag_id[rd_ptr];
        beat_last = beat_cnt == tag_bc[rd_ptr];
        tag_pop   = rd_valid && tag_any && beat_last;
    end

    assign m0_ready    = gnt0 && !rst;
    assign m1_ready    = gnt1 && !rst;
    assign m0_rd_valid = rd_valid && tag_any && !head_id && !rst;
    assign m1_rd_valid = rd_valid && tag_any && head_id && !rst;
    assign m0_rd_last  = m0_rd_valid && beat_last;
    assign m1_rd_last  = m1_rd_valid && beat_last;
    assign m0_rd_data  = rd_data;
    assign m1_rd_data  = rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            push_valid     <= 1'b0;
            push_cmd_type  <= 1'b0;
            push_addr      <= '0;
            push_burst_cnt <= '0;
            push_wt_data   <= '0;
            push_wt_mask   <= '0;
            last_grant     <= 1'b1;
        end else if (load) begin
            if (gnt0) begin
                push_valid     <= 1'b1;
                push_cmd_type  <= m0_cmd_type;
                push_addr      <= m0_addr;
                push_burst_cnt <= m0_burst_cnt;
                push_wt_data   <= m0_wt_data;
                push_wt_mask   <= m0_wt_mask;
                last_grant     <= 1'b0;
            end else if (gnt1) begin
                push_valid     <= 1'b1;
                push_cmd_type  <= m1_cmd_type;
                push_addr      <= m1_addr;
                push_burst_cnt <= m1_burst_cnt;
                push_wt_data   <= m1_wt_data;
                push_wt_mask   <= m1_wt_mask;
                last_grant     <= 1'b1;
            end else begin
                push_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_id[wr_ptr] <= gnt1;
            tag_bc[wr_ptr] <= gnt1 ? m1_burst_cnt : m0_burst_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_cnt  <= '0;
            beat_cnt <= '0;
            rd_err   <= 1'b0;
        end else begin
            if (tag_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (tag_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (tag_push && !tag_pop)
                tag_cnt <= tag_cnt + 1'b1;
            else if (tag_pop && !tag_push)
                tag_cnt <= tag_cnt - 1'b1;
            if (rd_valid && tag_any)
                beat_cnt <= beat_last ? 6'd0 : beat_cnt + 6'd1;
            if (rd_valid && !tag_any)
                rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_cmd_arbiter;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   v;
    logic [1:0]   t;
    logic [26:0]  a  [2];
    logic [5:0]   bc [2];
    logic [127:0] wd [2];
    logic [15:0]  wm [2];
    logic         push_ready;
    logic         rd_valid;
    logic [127:0] rd_data;

    logic         m0_ready, m1_ready;
    logic         push_valid, push_cmd_type;
    logic [26:0]  push_addr;
    logic [5:0]   push_burst_cnt;
    logic [127:0] push_wt_data;
    logic [15:0]  push_wt_mask;
    logic         m0_rd_valid, m0_rd_last, m1_rd_valid, m1_rd_last;
    logic [127:0] m0_rd_data, m1_rd_data;
    logic         rd_err;

    cmd_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(v[0]), .m0_ready(m0_ready), .m0_cmd_type(t[0]),
        .m0_addr(a[0]), .m0_burst_cnt(bc[0]), .m0_wt_data(wd[0]),
        .m0_wt_mask(wm[0]),
        .m1_valid(v[1]), .m1_ready(m1_ready), .m1_cmd_type(t[1]),
        .m1_addr(a[1]), .m1_burst_cnt(bc[1]), .m1_wt_data(wd[1]),
        .m1_wt_mask(wm[1]),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_cmd_type(push_cmd_type), .push_addr(push_addr),
        .push_burst_cnt(push_burst_cnt), .push_wt_data(push_wt_data),
        .push_wt_mask(push_wt_mask),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
        .m0_rd_last(m0_rd_last),
        .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
        .m1_rd_last(m1_rd_last),
        .rd_err(rd_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    int           last;
    bit           mpv;
    logic         mt;
    logic [26:0]  ma;
    logic [5:0]   mbc;
    logic [127:0] mwd;
    logic [15:0]  mwm;
    int           tq[$];
    int           beat;
    bit           merr;
    bit           autom;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        last = 1; mpv = 0; mt = 0; ma = 0; mbc = 0; mwd = 0; mwm = 0;
        tq.delete(); beat = 0; merr = 0;
    endtask

    task automatic new_cmd(int n, bit wr, logic [26:0] ad, logic [5:0] b);
        v[n] = 1'b1; t[n] = wr; a[n] = ad; bc[n] = b;
        wd[n] = rnd128(); wm[n] = 16'($urandom);
    endtask

    task automatic step();
        bit load;
        bit el [2];
        int gg, hid, hbc;
        bit hit, granted;
        #1;
        load = !mpv || push_ready;
        for (int n = 0; n < 2; n++)
            el[n] = v[n] && (t[n] || tq.size() < DEPTH);
        gg = -1;
        if (load) begin
            if (el[0] && el[1]) gg = (last == 0) ? 1 : 0;
            else if (el[0]) gg = 0;
            else if (el[1]) gg = 1;
        end
        granted = (gg >= 0) && !rst;
        hit = rd_valid && tq.size() > 0;
        hid = hit ? tq[0] / 64 : 0;
        hbc = hit ? tq[0] % 64 : 0;
        check("m0_ready", m0_ready, granted && gg == 0);
        check("m1_ready", m1_ready, granted && gg == 1);
        check("m0_rd_valid", m0_rd_valid, hit && hid == 0 && !rst);
        check("m1_rd_valid", m1_rd_valid, hit && hid == 1 && !rst);
        check("m0_rd_last", m0_rd_last, hit && hid == 0 && !rst && beat == hbc);
        check("m1_rd_last", m1_rd_last, hit && hid == 1 && !rst && beat == hbc);
        if (hit && !rst) begin
            if (hid == 0) check("m0_rd_data", m0_rd_data, rd_data);
            else check("m1_rd_data", m1_rd_data, rd_data);
        end
        check("push_valid", push_valid, mpv);
        check("push_cmd_type", push_cmd_type, mt);
        check("push_addr", push_addr, ma);
        check("push_burst_cnt", push_burst_cnt, mbc);
        check("push_wt_data", push_wt_data, mwd);
        check("push_wt_mask", push_wt_mask, mwm);
        check("rd_err", rd_err, merr);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (rd_valid) begin
                if (tq.size() == 0) merr = 1;
                else if (beat == hbc) begin
                    void'(tq.pop_front());
                    beat = 0;
                end else beat++;
            end
            if (gg >= 0) begin
                mpv = 1; mt = t[gg]; ma = a[gg]; mbc = bc[gg];
                mwd = wd[gg]; mwm = wm[gg]; last = gg;
                if (!t[gg]) tq.push_back(gg * 64 + int'(bc[gg]));
            end else if (load) mpv = 0;
        end
        @(negedge clk);
        if (granted) v[gg] = 1'b0;
        if (autom) begin
            for (int n = 0; n < 2; n++)
                if (!v[n] && $urandom_range(0, 2) == 0)
                    new_cmd(n, $urandom_range(0, 3) == 0, 27'($urandom),
                            6'($urandom_range(0, 3)));
            push_ready = $urandom_range(0, 3) != 0;
            rd_valid   = $urandom_range(0, 2) == 0;
            rd_data    = rnd128();
            rst        = $urandom_range(0, 199) == 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; rd_valid = 1'b0; push_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [26:0] held;

    initial begin
        autom = 0;
        rst = 1'b1; v = '0; t = '0; push_ready = 1'b1;
        rd_valid = 1'b0; rd_data = '0;
        for (int n = 0; n < 2; n++) begin
            a[n] = '0; bc[n] = '0; wd[n] = '0; wm[n] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        check("reset_push_valid", push_valid, 1'b0);
        check("reset_rd_err", rd_err, 1'b0);

        // Tie after reset: m0 first, then m1
        new_cmd(0, 0, 27'h100, 0);
        new_cmd(1, 0, 27'h200, 0);
        step();
        check("tie_first_addr", push_addr, 27'h100);
        step();
        check("tie_second_addr", push_addr, 27'h200);
        do_reset();

        // Backpressure with both requesters pending
        new_cmd(0, 1, 27'h11, 0);
        new_cmd(1, 1, 27'h22, 0);
        step();
        new_cmd(0, 1, 27'h33, 0);
        push_ready = 1'b0;
        held = push_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_addr", push_addr, held);
        end
        push_ready = 1'b1;
        step();
        check("bp_resume_addr", push_addr, 27'h22);
        do_reset();

        // Routing: m1 4 beats then m0 1 beat
        new_cmd(1, 0, 27'h1, 3);
        step();
        new_cmd(0, 0, 27'h2, 0);
        step();
        rd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_data = rnd128();
            step();
        end
        rd_valid = 1'b0;
        step();
        do_reset();

        // Tag full: 9th read stalls, write from m1 proceeds
        for (int i = 0; i < DEPTH; i++) begin
            new_cmd(0, 0, 27'(i), 0);
            step();
        end
        new_cmd(0, 0, 27'd99, 0);
        new_cmd(1, 1, 27'd77, 0);
        step();
        check("full_write_addr", push_addr, 27'd77);
        step();
        rd_valid = 1'b1; rd_data = rnd128();
        step();
        rd_valid = 1'b0;
        step();
        check("full_read_addr", push_addr, 27'd99);
        do_reset();

        // Error path, then reset clears it
        rd_valid = 1'b1; rd_data = rnd128();
        step();
        rd_valid = 1'b0;
        step();
        step();
        check("err_sticky", rd_err, 1'b1);
        do_reset();
        check("err_cleared", rd_err, 1'b0);

        // Reset mid-burst
        new_cmd(0, 0, 27'h5, 3);
        step();
        rd_valid = 1'b1; rd_data = rnd128();
        step();
        step();
        rd_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_push_valid", push_valid, 1'b0);
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        new_cmd(0, 0, 27'h6, 0);
        step();
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        do_reset();

        // Random traffic
        autom = 1;
        for (int i = 0; i < 3000; i++) step();
        autom = 0;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 8, meaning the maximum number of read commands in flight (power of 2, 2..32).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- mN_valid  in  1  requester N command valid (N = 0, 1).
- mN_ready  out  1  requester N command accepted this cycle.
- mN_cmd_type  in  1  0 = read, 1 = write.
- mN_addr  in  27  command address.
- mN_burst_cnt  in  6  beats minus one (1..64 beats).
- mN_wt_data  in  128  write data.
- mN_wt_mask  in  16  write byte mask.
- push_valid  out  1  command toward the command FIFO write side.
- push_ready  in  1  command FIFO not full.
- push_cmd_type  out  1  granted command type.
- push_addr  out  27  granted command address.
- push_burst_cnt  out  6  granted command burst count.
- push_wt_data  out  128  granted command write data.
- push_wt_mask  out  16  granted command write mask.
- rd_valid  in  1  read data beat returned (no backpressure).
- rd_data  in  128  read data beat.
- mN_rd_valid  out  1  read beat routed to requester N.
- mN_rd_data  out  128  routed read beat.
- mN_rd_last  out  1  final beat of the burst.
- rd_err  out  1  sticky: beat arrived with no outstanding read.

Function
REQ-003 SHALL hold the granted command in one output register; push_valid SHALL be that register's valid bit, and push_* SHALL be register outputs.
REQ-004 SHALL load the output register ("load slot") when push_valid=0 or push_ready=1.
REQ-005 SHALL treat requester N as eligible when mN_valid=1 and either mN_cmd_type=1 or tag count < TAG_DEPTH.
REQ-006 SHALL, in a load slot, grant the single eligible requester; if both are eligible, it SHALL grant the one not granted last (round-robin).
REQ-007 SHALL assert mN_ready for exactly the cycle of requester N's grant, combinationally; at most one mN_ready SHALL be high per cycle.
REQ-008 SHALL update the last-grant pointer only on a grant.
REQ-009 SHALL clear push_valid in a load slot with no grant.
REQ-010 SHALL hold push_* stable while push_valid=1 and push_ready=0.
REQ-011 SHALL, on a read grant, push {requester id, burst_cnt} into an internal tag FIFO of TAG_DEPTH entries in the same cycle; write grants SHALL NOT push a tag.
REQ-012 SHALL NOT free a tag slot for a grant decision in the cycle the tag is popped (the full check uses the registered count).
REQ-013 SHALL route each rd_valid beat to the requester named by the tag FIFO head: mN_rd_valid=1 and mN_rd_data=rd_data in the same cycle (combinational, zero latency).
REQ-014 SHALL count beats with a 6-bit counter; on the beat where counter = head burst_cnt it SHALL assert mN_rd_last, pop the head tag and clear the counter; otherwise it SHALL increment the counter.
REQ-015 SHALL handle a tag push and pop in the same cycle with the count unchanged and order preserved.
REQ-016 SHALL, for rd_valid with an empty tag FIFO, set rd_err, drop the beat (no mN_rd_valid) and leave the counter unchanged.
REQ-017 SHALL allow an empty-FIFO read grant to be popped no earlier than the cycle after the grant.

Reset
REQ-018 SHALL, with rst=1 at a clk edge, clear push_valid, all push_* data registers, the tag FIFO (count 0), the beat counter and rd_err, and set the last-grant pointer to 1 so requester 0 wins the first tie.
REQ-019 SHALL hold mN_ready and mN_rd_valid at 0 while rst=1.
REQ-020 SHALL discard in-flight bursts on reset mid-operation; beats arriving after reset with no new read SHALL set rd_err.

Verification
REQ-021 SHALL cover a tie after reset: m0 and m1 both send reads, push_ready=1 -> m0 granted in cycle 1, m1 in cycle 2, push_addr follows the same order.
REQ-022 SHALL cover backpressure: push_ready=0 for 5 cycles with both requesters valid -> push_* stays constant, no mN_ready, grant resumes on the first push_ready=1.
REQ-023 SHALL cover routing: m1 read burst_cnt=3 then m0 read burst_cnt=0, 5 rd_valid beats -> 4 beats to m1 (last on beat 4), 1 beat to m0 with rd_last.
REQ-024 SHALL cover tag-full: TAG_DEPTH=8, 8 reads outstanding -> a 9th read stalls while a write from the other requester is granted; the read is granted the cycle after the first tag pop.
REQ-025 SHALL cover the error path: rd_valid with no outstanding read -> rd_err=1 stays set, no mN_rd_valid; a following rst=1 clears it.
REQ-026 SHALL cover reset mid-burst: rst after 2 of 4 beats -> tag count 0, push_valid=0, counter 0.
